// File: rtl/wide_operand_buffer_if.sv
// Bundle of processor-side word port, core-side operand/result handshake and status
// for wide_operand_buffer. slave = buffer view, master = processor/core view.
interface wide_operand_buffer_if #(
  parameter int WORD_WIDTH     = 32,
  parameter int REG_DATA_WIDTH = 1024,
  parameter int NUM_OPERANDS   = 3,
  parameter int ADDR_WIDTH     = 10
);
  localparam int SB = $clog2(NUM_OPERANDS + 1);

  logic                      wr_en;
  logic [ADDR_WIDTH-1:0]     wr_addr;
  logic [WORD_WIDTH-1:0]     wr_data;
  logic                      rd_en;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic [WORD_WIDTH-1:0]     rd_data;
  logic                      rd_valid;
  logic                      start;
  logic [REG_DATA_WIDTH-1:0] op_data;
  logic [SB-1:0]             op_sel;
  logic                      op_valid;
  logic                      op_read;
  logic [REG_DATA_WIDTH-1:0] res_data;
  logic                      res_valid;
  logic                      res_read;
  logic                      busy;
  logic                      done;
  logic                      err;

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, start, op_read, res_data, res_valid,
    output rd_data, rd_valid, op_data, op_sel, op_valid, res_read, busy, done, err
  );

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, start, op_read, res_data, res_valid,
    input  rd_data, rd_valid, op_data, op_sel, op_valid, res_read, busy, done, err
  );
endinterface

// File: rtl/wide_operand_buffer.sv
// Word-addressed operand/result buffer that streams NUM_OPERANDS wide operands to the core
// and captures one wide result. Optional load mask: define WIDE_BUF_LOADMASK_EN.
module wide_operand_buffer #(
  parameter int WORD_WIDTH     = 32,
  parameter int REG_DATA_WIDTH = 1024,
  parameter int NUM_OPERANDS   = 3,
  parameter int ADDR_WIDTH     = 10
) (
  input  logic                 clk,
  input  logic                 resetn,
  wide_operand_buffer_if.slave bus
);
  localparam int WPR = REG_DATA_WIDTH / WORD_WIDTH;
  localparam int WB  = $clog2(WPR);
  localparam int SB  = $clog2(NUM_OPERANDS + 1);
  localparam int UB  = ADDR_WIDTH - WB;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RES, DONE} state_t;

  state_t                  state_q, state_d;
  logic [SB-1:0]           k_q, k_d;
  logic                    err_q, err_d;
  logic [WORD_WIDTH-1:0]   mem_q [NUM_OPERANDS][WPR];
  logic [WORD_WIDTH-1:0]   res_q [WPR];
  logic [WORD_WIDTH-1:0]   rd_data_q, rd_word_d;
  logic                    rd_valid_q;
  logic [REG_DATA_WIDTH-1:0] op_data_d;

  // The whole upper address field is decoded so slots beyond the result slot are reachable.
  logic [UB-1:0] wr_slot, rd_slot;
  logic [WB-1:0] wr_word, rd_word;
  assign wr_slot = bus.wr_addr[ADDR_WIDTH-1:WB];
  assign wr_word = bus.wr_addr[WB-1:0];
  assign rd_slot = bus.rd_addr[ADDR_WIDTH-1:WB];
  assign rd_word = bus.rd_addr[WB-1:0];

  logic start_ok, wr_ok, wr_bad, start_go, start_bad;
  assign wr_ok     = bus.wr_en && (state_q == IDLE) && (wr_slot < UB'(NUM_OPERANDS));
  assign wr_bad    = bus.wr_en && !wr_ok;
  assign start_go  = bus.start && (state_q == IDLE) && start_ok;
  assign start_bad = bus.start && !start_go;

`ifdef WIDE_BUF_LOADMASK_EN
  logic [NUM_OPERANDS-1:0][WPR-1:0] mask_q;

  function automatic logic [WORD_WIDTH-1:0] popcount(input logic [NUM_OPERANDS*WPR-1:0] v);
    logic [WORD_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_OPERANDS * WPR; i++) n = n + WORD_WIDTH'(v[i]);
    return n;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mask_q <= '0;
    end else if (state_q == DONE) begin
      mask_q <= '0;
    end else if (wr_ok) begin
      for (int s = 0; s < NUM_OPERANDS; s++)
        if (wr_slot == UB'(s)) mask_q[s][wr_word] <= 1'b1;
    end
  end

  assign start_ok = &mask_q;
`else
  assign start_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_go) begin
          state_d = SEND;
          k_d     = '0;
          err_d   = 1'b0;
        end
      end
      SEND: begin
        if (bus.op_read) begin
          if (k_q == SB'(NUM_OPERANDS - 1)) state_d = WAIT_RES;
          else                              k_d     = k_q + 1'b1;
        end
      end
      WAIT_RES: if (bus.res_valid) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // Protocol violations win over the clear that an accepted start performs.
    if (wr_bad || start_bad) err_d = 1'b1;
  end

  always_comb begin
    rd_word_d = '0;
    for (int s = 0; s < NUM_OPERANDS; s++)
      if (rd_slot == UB'(s)) rd_word_d = mem_q[s][rd_word];
    if (rd_slot == UB'(NUM_OPERANDS)) rd_word_d = res_q[rd_word];
`ifdef WIDE_BUF_LOADMASK_EN
    if (rd_slot == UB'(NUM_OPERANDS + 1) && rd_word == '0) rd_word_d = popcount(mask_q);
`endif
  end

  always_comb begin
    op_data_d = '0;
    if (state_q == SEND)
      for (int s = 0; s < NUM_OPERANDS; s++)
        if (k_q == SB'(s))
          for (int w = 0; w < WPR; w++) op_data_d[w*WORD_WIDTH +: WORD_WIDTH] = mem_q[s][w];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < NUM_OPERANDS; s++)
        for (int w = 0; w < WPR; w++) mem_q[s][w] <= '0;
      for (int w = 0; w < WPR; w++) res_q[w] <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_ok)
        for (int s = 0; s < NUM_OPERANDS; s++)
          if (wr_slot == UB'(s)) mem_q[s][wr_word] <= bus.wr_data;
      if (state_q == WAIT_RES && bus.res_valid)
        for (int w = 0; w < WPR; w++) res_q[w] <= bus.res_data[w*WORD_WIDTH +: WORD_WIDTH];
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= rd_word_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.op_data  = op_data_d;
  assign bus.op_sel   = (state_q == SEND) ? k_q : '0;
  assign bus.op_valid = (state_q == SEND);
  assign bus.res_read = (state_q == WAIT_RES);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.err      = err_q;
endmodule

// File: tb/tb_wide_operand_buffer.sv
// Self-checking bench for wide_operand_buffer: vector table, directed sequences and
// randomized jobs against a slot/word array model.
module tb_wide_operand_buffer;
  localparam int WW  = 32;
  localparam int RW  = 1024;
  localparam int N   = 3;
  localparam int AW  = 10;
  localparam int WPR = RW / WW;
`ifdef WIDE_BUF_LOADMASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  wide_operand_buffer_if #(.WORD_WIDTH(WW), .REG_DATA_WIDTH(RW), .NUM_OPERANDS(N), .ADDR_WIDTH(AW)) bus ();
  wide_operand_buffer #(.WORD_WIDTH(WW), .REG_DATA_WIDTH(RW), .NUM_OPERANDS(N), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [WW-1:0] model_mem [N][WPR];
  logic [WW-1:0] model_res [WPR];
  bit            model_mask [N][WPR];
  bit            model_err;
  int            stall_cfg [N];

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [WW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic [WW-1:0] exp_rd;
    logic          exp_err;
  } vec_t;
  vec_t vecs [12];

  function automatic logic [AW-1:0] A(input int s, input int w);
    return AW'(s * WPR + w);
  endfunction

  function automatic int model_pop();
    int n = 0;
    for (int s = 0; s < N; s++)
      for (int w = 0; w < WPR; w++) n += int'(model_mask[s][w]);
    return n;
  endfunction

  function automatic logic [WW-1:0] exp_word(input int s, input int w);
    if (s < N) return model_mem[s][w];
    if (s == N) return model_res[w];
    if (s == N + 1 && w == 0 && MASK_EN) return WW'(model_pop());
    return '0;
  endfunction

  function automatic logic [RW-1:0] op_exp(input int s);
    logic [RW-1:0] v;
    for (int w = 0; w < WPR; w++) v[w*WW +: WW] = model_mem[s][w];
    return v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < N; s++)
      for (int w = 0; w < WPR; w++) begin
        model_mem[s][w] = '0;
        model_mask[s][w] = 1'b0;
      end
    for (int w = 0; w < WPR; w++) model_res[w] = '0;
    model_err = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got low64 %0h expected low64 %0h", nm, act[63:0], exp[63:0]);
    end
  endtask

  task automatic wr(input int s, input int w, input logic [WW-1:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = A(s, w); bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    if (s < N) begin
      model_mem[s][w] = d;
      model_mask[s][w] = 1'b1;
    end else model_err = 1'b1;
  endtask

  task automatic rd_chk(input string nm, input int s, input int w, input logic [WW-1:0] exp);
    bus.rd_en = 1'b1; bus.rd_addr = A(s, w);
    tick();
    bus.rd_en = 1'b0;
    chk({nm, " rd_valid"}, 64'(bus.rd_valid), 64'(1));
    chk(nm, 64'(bus.rd_data), 64'(exp));
  endtask

  task automatic load_all(input bit pattern);
    for (int s = 0; s < N; s++)
      for (int w = 0; w < WPR; w++)
        wr(s, w, pattern ? WW'(32'h100 * s + w) : WW'($urandom));
  endtask

  task automatic run_job(input int rdly, input logic [RW-1:0] rdata, input bit inj_wr, input bit inj_start);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    model_err = 1'b0;
    chk("busy after start", 64'(bus.busy), 64'(1));
    chk("err cleared by start", 64'(bus.err), 64'(model_err));
    for (int idx = 0; idx < N; idx++) begin
      for (int c = 0; c <= stall_cfg[idx]; c++) begin
        chk($sformatf("op_valid k%0d c%0d", idx, c), 64'(bus.op_valid), 64'(1));
        chk($sformatf("op_sel k%0d c%0d", idx, c), 64'(bus.op_sel), 64'(idx));
        chk_w($sformatf("op_data k%0d c%0d", idx, c), bus.op_data, op_exp(idx));
        chk($sformatf("done early k%0d", idx), 64'(bus.done), 64'(0));
        if (inj_wr && idx == 0 && c == 0) begin
          bus.wr_en = 1'b1; bus.wr_addr = A(1, 0); bus.wr_data = 32'hDEAD;
          model_err = 1'b1;
        end
        if (inj_start && idx == N - 1 && c == 0) begin
          bus.start = 1'b1;
          model_err = 1'b1;
        end
        bus.op_read = (c == stall_cfg[idx]);
        tick();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        chk($sformatf("err k%0d c%0d", idx, c), 64'(bus.err), 64'(model_err));
      end
    end
    bus.op_read = 1'b0;
    for (int d = 0; d <= rdly; d++) begin
      chk("res_read in wait", 64'(bus.res_read), 64'(1));
      chk("op_valid in wait", 64'(bus.op_valid), 64'(0));
      chk("done in wait", 64'(bus.done), 64'(0));
      bus.res_valid = (d == rdly);
      bus.res_data = rdata;
      tick();
    end
    bus.res_valid = 1'b0;
    chk("done pulse", 64'(bus.done), 64'(1));
    chk("busy in done", 64'(bus.busy), 64'(1));
    chk("res_read after capture", 64'(bus.res_read), 64'(0));
    for (int w = 0; w < WPR; w++) model_res[w] = rdata[w*WW +: WW];
    for (int s = 0; s < N; s++)
      for (int w = 0; w < WPR; w++) model_mask[s][w] = 1'b0;
    tick();
    chk("done one cycle", 64'(bus.done), 64'(0));
    chk("busy back to idle", 64'(bus.busy), 64'(0));
    chk("err after job", 64'(bus.err), 64'(model_err));
  endtask

  initial begin
    logic [RW-1:0] rdata;
    int seen;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en = 0; bus.rd_addr = '0; bus.start = 0;
    bus.op_read = 0; bus.res_data = '0; bus.res_valid = 0;
    model_reset();

    repeat (3) tick();
    chk("reset rd_data", 64'(bus.rd_data), 64'(0));
    chk("reset rd_valid", 64'(bus.rd_valid), 64'(0));
    chk("reset busy", 64'(bus.busy), 64'(0));
    chk("reset op_valid", 64'(bus.op_valid), 64'(0));
    chk("reset res_read", 64'(bus.res_read), 64'(0));
    chk("reset done", 64'(bus.done), 64'(0));
    chk("reset err", 64'(bus.err), 64'(0));
    resetn = 1'b1;
    tick();

    vecs[0]  = '{1'b1, A(0, 3),  32'h11,        1'b0, A(0, 0),  32'h0,        1'b0};
    vecs[1]  = '{1'b1, A(0, 3),  32'h22,        1'b1, A(0, 3),  32'h11,       1'b0};
    vecs[2]  = '{1'b0, A(0, 0),  32'h0,         1'b1, A(0, 3),  32'h22,       1'b0};
    vecs[3]  = '{1'b1, A(2, 31), 32'hCAFE_F00D, 1'b1, A(2, 31), 32'h0,        1'b0};
    vecs[4]  = '{1'b0, A(0, 0),  32'h0,         1'b1, A(2, 31), 32'hCAFE_F00D, 1'b0};
    vecs[5]  = '{1'b0, A(0, 0),  32'h0,         1'b1, A(N, 0),  32'h0,        1'b0};
    vecs[6]  = '{1'b0, A(0, 0),  32'h0,         1'b1, A(N+1, 0), MASK_EN ? 32'd2 : 32'd0, 1'b0};
    vecs[7]  = '{1'b0, A(0, 0),  32'h0,         1'b1, A(6, 4),  32'h0,        1'b0};
    vecs[8]  = '{1'b1, A(N, 0),  32'h1234,      1'b1, A(1, 0),  32'h0,        1'b1};
    vecs[9]  = '{1'b0, A(0, 0),  32'h0,         1'b1, A(N, 0),  32'h0,        1'b1};
    vecs[10] = '{1'b1, A(7, 1),  32'h55,        1'b1, A(7, 1),  32'h0,        1'b1};
    vecs[11] = '{1'b0, A(0, 0),  32'h0,         1'b1, A(1, 5),  32'h0,        1'b1};

    for (int i = 0; i < 12; i++) begin
      bus.wr_en = vecs[i].we; bus.wr_addr = vecs[i].wa; bus.wr_data = vecs[i].wd;
      bus.rd_en = vecs[i].re; bus.rd_addr = vecs[i].ra;
      tick();
      bus.wr_en = 1'b0; bus.rd_en = 1'b0;
      if (vecs[i].we && int'(vecs[i].wa) / WPR < N) begin
        model_mem[int'(vecs[i].wa) / WPR][int'(vecs[i].wa) % WPR] = vecs[i].wd;
        model_mask[int'(vecs[i].wa) / WPR][int'(vecs[i].wa) % WPR] = 1'b1;
      end
      chk($sformatf("vec%0d rd_valid", i), 64'(bus.rd_valid), 64'(vecs[i].re));
      if (vecs[i].re) chk($sformatf("vec%0d rd_data", i), 64'(bus.rd_data), 64'(vecs[i].exp_rd));
      chk($sformatf("vec%0d err", i), 64'(bus.err), 64'(vecs[i].exp_err));
    end
    tick();
    chk("rd_valid single pulse", 64'(bus.rd_valid), 64'(0));

    // Default job: pattern operands, no stalls, result word i = A5A5_0000+i.
    load_all(1'b1);
    rd_chk("popcount full", N + 1, 0, exp_word(N + 1, 0));
    for (int w = 0; w < WPR; w++) rdata[w*WW +: WW] = 32'hA5A5_0000 + w;
    for (int i = 0; i < N; i++) stall_cfg[i] = 0;
    run_job(0, rdata, 1'b0, 1'b0);
    rd_chk("result word 5", N, 5, 32'hA5A5_0005);
    rd_chk("slot1 word2", 1, 2, 32'h102);
    rd_chk("popcount after done", N + 1, 0, 32'h0);

    // op_read and res_valid in IDLE must not do anything.
    bus.op_read = 1'b1; bus.res_valid = 1'b1; bus.res_data = '1;
    tick();
    bus.op_read = 1'b0; bus.res_valid = 1'b0;
    chk("idle op_read ignored busy", 64'(bus.busy), 64'(0));
    chk("idle op_valid", 64'(bus.op_valid), 64'(0));
    rd_chk("idle res_valid ignored", N, 5, 32'hA5A5_0005);

    // Three stall cycles per operand.
    load_all(1'b1);
    for (int i = 0; i < N; i++) stall_cfg[i] = 3;
    for (int w = 0; w < WPR; w++) rdata[w*WW +: WW] = $urandom;
    run_job(0, rdata, 1'b0, 1'b0);
    rd_chk("stall result w7", N, 7, model_res[7]);

    // Illegal write and extra start while busy.
    load_all(1'b1);
    for (int i = 0; i < N; i++) stall_cfg[i] = 1;
    run_job(2, rdata, 1'b1, 1'b1);
    rd_chk("write during send ignored", 1, 0, 32'h100);
    chk("err sticky after done", 64'(bus.err), 64'(1));

    for (int j = 0; j < 6; j++) begin
      load_all(1'b0);
      for (int i = 0; i < N; i++) stall_cfg[i] = int'($urandom_range(3, 0));
      for (int w = 0; w < WPR; w++) rdata[w*WW +: WW] = $urandom;
      run_job(int'($urandom_range(3, 0)), rdata, 1'b0, 1'b0);
      for (int r = 0; r < 3; r++) begin
        int w = int'($urandom_range(WPR - 1, 0));
        rd_chk($sformatf("rand%0d result w%0d", j, w), N, w, exp_word(N, w));
      end
      for (int r = 0; r < 2; r++) begin
        int s = int'($urandom_range(N - 1, 0));
        int w = int'($urandom_range(WPR - 1, 0));
        rd_chk($sformatf("rand%0d slot%0d w%0d", j, s, w), s, w, exp_word(s, w));
      end
      rd_chk($sformatf("rand%0d popcount", j), N + 1, 0, exp_word(N + 1, 0));
    end

    // Load everything except slot 2 word 31.
    for (int s = 0; s < N; s++)
      for (int w = 0; w < WPR; w++)
        if (!(s == 2 && w == 31)) wr(s, w, WW'($urandom));
    rd_chk("popcount partial", N + 1, 0, exp_word(N + 1, 0));
`ifdef WIDE_BUF_LOADMASK_EN
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    model_err = 1'b1;
    chk("refused start busy", 64'(bus.busy), 64'(0));
    chk("refused start op_valid", 64'(bus.op_valid), 64'(0));
    chk("refused start err", 64'(bus.err), 64'(1));
    rd_chk("popcount 95", N + 1, 0, 32'd95);
`else
    for (int i = 0; i < N; i++) stall_cfg[i] = 0;
    run_job(1, rdata, 1'b0, 1'b0);
    rd_chk("slot N+1 reads zero", N + 1, 0, 32'h0);
`endif

    // Reset while waiting for the result.
    load_all(1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.op_read = 1'b1;
    repeat (N) tick();
    bus.op_read = 1'b0;
    chk("in wait res_read", 64'(bus.res_read), 64'(1));
    rd_chk("read during wait", 0, 1, exp_word(0, 1));
    resetn = 1'b0;
    #1;
    chk("async reset busy", 64'(bus.busy), 64'(0));
    chk("async reset res_read", 64'(bus.res_read), 64'(0));
    chk("async reset rd_data", 64'(bus.rd_data), 64'(0));
    chk("async reset err", 64'(bus.err), 64'(0));
    chk("async reset done", 64'(bus.done), 64'(0));
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.done) seen++;
      tick();
    end
    chk("no done after reset", 64'(seen), 64'(0));
    for (int s = 0; s <= N; s++)
      for (int w = 0; w < WPR; w++)
        rd_chk($sformatf("post-reset s%0d w%0d", s, w), s, w, exp_word(s, w));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
